auth_responder_mc: RTL and testbench
====================================

# auth_responder_mc

Parametrised, multi-slot USB Type-C authentication responder. It queues incoming authentication requests and validates each header. Valid GET_DIGESTS, GET_CERTIFICATE and CHALLENGE requests are dispatched to an external answer engine; malformed, unsupported, busy or timed-out requests get an ERROR response. The block sits between the USB control-transfer front end and the digest/certificate/challenge answer generators, and replaces the fixed single-request responder.

## Interface
- MSG_LEN, 512: request/response message width in bits; header is the top 32 bits.
- NUM_SLOTS, 4: number of certificate slots (≥2); slot index width SW = $clog2(NUM_SLOTS).
- QUEUE_DEPTH, 2: request FIFO depth (≥1).
- TIMEOUT_CYC, 1000: max cycles waiting for the answer engine.
- PROTO_VER, 8'h01: accepted ProtocolVersion.

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  FIFO can accept (= !full && !reset)
- req_msg  in  MSG_LEN  {ProtocolVersion[8], MessageType[8], Param1[8], Param2[8], body}
- slot_valid_mask  in  NUM_SLOTS  provisioned slots
- busy_in  in  1  device busy; sampled in DECODE
- ans_start  out  1  one-cycle dispatch pulse
- ans_type  out  2  0=digests, 1=certificate, 2=challenge
- ans_slot  out  SW  target slot
- ans_req_body  out  MSG_LEN-32  body of dispatched request (challenge nonce, cert offset)
- ans_done  in  1  answer ready
- ans_error  in  1  engine failure, qualified by ans_done
- ans_header / ans_payload / ans_len  in  32 / MSG_LEN-32 / 16  answer contents, qualified by ans_done
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  response consumed
- rsp_header / rsp_payload  out  32 / MSG_LEN-32
- bmRequestType, bRequest  out  8 each
- wLength  out  16
- timeout_err  out  1  one-cycle pulse on engine timeout

## Operation
- FIFO push on req_valid && req_ready. No bypass: when full, req_ready=0 even if a pop occurs in the same cycle.
- States: IDLE, DECODE, DISPATCH, WAIT_ANS, SEND.
- IDLE: if FIFO non-empty, pop the head into the request register → DECODE.
- DECODE (one cycle) checks, first match wins. Error header = {PROTO_VER, 8'h7F, code, 8'h00}.
  - ProtocolVersion != PROTO_VER → UnsupportedProtocol, code 2.
  - MessageType not in {0x81, 0x82, 0x83} → Invalid, code 1.
  - busy_in=1 → Busy, code 3.
  - For 0x82/0x83 only: Param1 ≥ NUM_SLOTS or slot_valid_mask[Param1]=0 → Invalid, code 1.
  - Error → SEND with rsp_payload=0, wLength=4.
  - Otherwise → DISPATCH.
- DISPATCH: ans_start=1 for exactly one cycle.
  - ans_type = MessageType-0x81.
  - ans_slot = Param1[SW-1:0] (0 for digests).
  - Clear timeout counter → WAIT_ANS.
- WAIT_ANS: counter increments each cycle.
  - ans_done && !ans_error: latch ans_header/ans_payload; wLength=ans_len → SEND.
  - ans_done && ans_error: Unspecified error response, code 4 → SEND.
  - Counter reaches TIMEOUT_CYC without ans_done: timeout_err pulse; Unspecified error, code 4 → SEND.
  - ans_done in the same cycle as timeout: ans_done wins, no timeout_err.
- USB fields:
  - Digests: bmRequestType=0x80, bRequest=0x18.
  - All others, including errors: 0x00, 0x19.
  - For digests, wLength = 4 + 32·popcount(slot_valid_mask), overriding ans_len; the 16-bit result must not truncate.
- SEND: rsp_valid=1; all rsp_* fields stable until rsp_valid && rsp_ready, then → IDLE.
- Responses are issued strictly in request arrival order; one request is in flight at a time.
- ans_done outside WAIT_ANS is ignored.

## Timing
- Reset, synchronous, any state:
  - FIFO flushed, state=IDLE, counter=0.
  - All outputs 0: req_ready, ans_*, rsp_*, bmRequestType, bRequest, wLength, timeout_err.
  - An in-flight engine answer is discarded.
- Latency from push at cycle 0:
  - Pop at cycle 1, DECODE at cycle 2.
  - Error path: rsp_valid at cycle 3.
  - Valid path: ans_start at cycle 3; ans_done at cycle k gives rsp_valid at k+1.
- Timeout: timeout_err and the move to SEND happen in the cycle the counter equals TIMEOUT_CYC, i.e. TIMEOUT_CYC cycles after entering WAIT_ANS; rsp_valid follows in the next cycle.
- Back-to-back: the next request's pop occurs in the cycle after the rsp handshake (IDLE visit of one cycle).
- Counter width $clog2(TIMEOUT_CYC+1); no wrap.

## Test plan
- GET_DIGESTS {01,81,00,00}, mask=4'b0011:
  - ans_start at +3 with ans_type=0.
  - ans_done 5 cycles later → rsp_valid with bmRequestType=0x80, bRequest=0x18, wLength=68.
- CHALLENGE {01,83,02,00}, mask=4'b0100 → ans_slot=2, ans_type=2; ans_header returned verbatim; rsp_ready held low 3 cycles → fields stable.
- Error matrix, each → rsp_header with the code shown and wLength=4:
  - ProtocolVersion 02 → {01,7F,02,00}.
  - MessageType 0x85 → code 1.
  - busy_in=1 → code 3.
  - GET_CERTIFICATE slot 3 with mask bit 3 clear → code 1.
- TIMEOUT_CYC=8, no ans_done → timeout_err pulse 8 cycles after WAIT_ANS entry, then {01,7F,04,00}; ans_done in the timeout cycle → normal response, no pulse.
- QUEUE_DEPTH=2: three requests pushed while the first is in WAIT_ANS → req_ready drops after two; responses come out in order.
- reset asserted during WAIT_ANS → next cycle all outputs 0, FIFO empty; a late ans_done is ignored; a following request completes normally.

Source files
------------

// File: rtl/auth_responder_mc.sv
// Multi-slot USB Type-C authentication responder: queues requests, validates
// headers, dispatches to an answer engine with timeout and returns responses in order.
module auth_responder_mc #(
  parameter int         MSG_LEN     = 512,
  parameter int         NUM_SLOTS   = 4,
  parameter int         QUEUE_DEPTH = 2,
  parameter int         TIMEOUT_CYC = 1000,
  parameter logic [7:0] PROTO_VER   = 8'h01,
  localparam int        SW          = $clog2(NUM_SLOTS),
  localparam int        BW          = MSG_LEN - 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [MSG_LEN-1:0]   req_msg,
  input  logic [NUM_SLOTS-1:0] slot_valid_mask,
  input  logic                 busy_in,
  output logic                 ans_start,
  output logic [1:0]           ans_type,
  output logic [SW-1:0]        ans_slot,
  output logic [BW-1:0]        ans_req_body,
  input  logic                 ans_done,
  input  logic                 ans_error,
  input  logic [31:0]          ans_header,
  input  logic [BW-1:0]        ans_payload,
  input  logic [15:0]          ans_len,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_header,
  output logic [BW-1:0]        rsp_payload,
  output logic [7:0]           bmRequestType,
  output logic [7:0]           bRequest,
  output logic [15:0]          wLength,
  output logic                 timeout_err
);

  localparam int PW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNTW = $clog2(QUEUE_DEPTH + 1);
  localparam int CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);

  localparam logic [7:0] MT_DIGESTS   = 8'h81;
  localparam logic [7:0] MT_CERT      = 8'h82;
  localparam logic [7:0] MT_CHALLENGE = 8'h83;
  localparam logic [7:0] ERR_INVALID  = 8'h01;
  localparam logic [7:0] ERR_PROTO    = 8'h02;
  localparam logic [7:0] ERR_BUSY     = 8'h03;
  localparam logic [7:0] ERR_UNSPEC   = 8'h04;

  typedef enum logic [2:0] {IDLE, DECODE, DISPATCH, WAIT_ANS, SEND} state_t;

  state_t state_q, state_d;

  logic [MSG_LEN-1:0] mem [QUEUE_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CNTW-1:0]    count_q;
  logic               full, push, pop;

  logic [MSG_LEN-1:0] req_q;
  logic [CW-1:0]      cnt_q;
  logic [7:0]         ver, mtype, p1, dec_code, err_code;
  logic               dispatch, load_err, load_ans;
  logic               unused_param2;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // 16-bit sum holds 4 + 32*NUM_SLOTS for any practical slot count.
  function automatic logic [15:0] digest_len(input logic [NUM_SLOTS-1:0] mask);
    logic [15:0] len;
    len = 16'd4;
    for (int i = 0; i < NUM_SLOTS; i++) if (mask[i]) len = len + 16'd32;
    return len;
  endfunction

  assign full      = (count_q == CNTW'(QUEUE_DEPTH));
  assign req_ready = !full && !reset;
  assign push      = req_valid && req_ready;

  assign ver   = req_q[MSG_LEN-1  -: 8];
  assign mtype = req_q[MSG_LEN-9  -: 8];
  assign p1    = req_q[MSG_LEN-17 -: 8];
  // Param2 carries no meaning for the supported requests.
  assign unused_param2 = ^req_q[BW +: 8];

  assign ans_start = (state_q == DISPATCH);
  assign rsp_valid = (state_q == SEND);

  // Header checks in priority order; zero means the request is dispatchable.
  always_comb begin
    dec_code = 8'h00;
    if (ver != PROTO_VER)
      dec_code = ERR_PROTO;
    else if (!(mtype inside {MT_DIGESTS, MT_CERT, MT_CHALLENGE}))
      dec_code = ERR_INVALID;
    else if (busy_in)
      dec_code = ERR_BUSY;
    else if (mtype != MT_DIGESTS &&
             (int'(p1) >= NUM_SLOTS || !slot_valid_mask[p1[SW-1:0]]))
      dec_code = ERR_INVALID;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    pop         = 1'b0;
    dispatch    = 1'b0;
    load_err    = 1'b0;
    load_ans    = 1'b0;
    err_code    = 8'h00;
    timeout_err = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) begin
        pop     = 1'b1;
        state_d = DECODE;
      end
      DECODE: if (dec_code != 8'h00) begin
        load_err = 1'b1;
        err_code = dec_code;
        state_d  = SEND;
      end else begin
        dispatch = 1'b1;
        state_d  = DISPATCH;
      end
      DISPATCH: state_d = WAIT_ANS;
      WAIT_ANS: if (ans_done) begin
        state_d = SEND;
        if (ans_error) begin
          load_err = 1'b1;
          err_code = ERR_UNSPEC;
        end else begin
          load_ans = 1'b1;
        end
      end else if (cnt_q == TMAX) begin
        timeout_err = 1'b1;
        load_err    = 1'b1;
        err_code    = ERR_UNSPEC;
        state_d     = SEND;
      end
      SEND: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the queue storage has no reset; occupancy lives in the reset pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_msg;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      req_q         <= '0;
      cnt_q         <= '0;
      ans_type      <= '0;
      ans_slot      <= '0;
      ans_req_body  <= '0;
      rsp_header    <= '0;
      rsp_payload   <= '0;
      bmRequestType <= '0;
      bRequest      <= '0;
      wLength       <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_q + CNTW'(push) - CNTW'(pop);
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop) begin
        req_q  <= mem[rd_ptr];
        rd_ptr <= ptr_next(rd_ptr);
      end

      if (dispatch) begin
        ans_type     <= mtype[1:0] - 2'd1;
        ans_slot     <= (mtype == MT_DIGESTS) ? '0 : p1[SW-1:0];
        ans_req_body <= req_q[BW-1:0];
      end

      if (state_q == DISPATCH)
        cnt_q <= '0;
      else if (state_q == WAIT_ANS && cnt_q != TMAX)
        cnt_q <= cnt_q + CW'(1);

      if (load_err) begin
        rsp_header    <= {PROTO_VER, 8'h7F, err_code, 8'h00};
        rsp_payload   <= '0;
        bmRequestType <= 8'h00;
        bRequest      <= 8'h19;
        wLength       <= 16'd4;
      end else if (load_ans) begin
        rsp_header  <= ans_header;
        rsp_payload <= ans_payload;
        if (ans_type == 2'd0) begin
          bmRequestType <= 8'h80;
          bRequest      <= 8'h18;
          wLength       <= digest_len(slot_valid_mask);
        end else begin
          bmRequestType <= 8'h00;
          bRequest      <= 8'h19;
          wLength       <= ans_len;
        end
      end
    end
  end

endmodule

// File: tb/tb_auth_responder_mc.sv
// Scoreboard bench for auth_responder_mc: expected responses are queued as
// requests are driven and compared when the responder presents them.
module tb_auth_responder_mc;
  localparam int MSG_LEN     = 64;
  localparam int NUM_SLOTS   = 4;
  localparam int QUEUE_DEPTH = 2;
  localparam int TIMEOUT_CYC = 8;
  localparam int SW          = $clog2(NUM_SLOTS);
  localparam int BW          = MSG_LEN - 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [MSG_LEN-1:0]   req_msg = '0;
  logic [NUM_SLOTS-1:0] slot_valid_mask = '0;
  logic                 busy_in = 1'b0;
  logic                 ans_start;
  logic [1:0]           ans_type;
  logic [SW-1:0]        ans_slot;
  logic [BW-1:0]        ans_req_body;
  logic                 ans_done = 1'b0;
  logic                 ans_error = 1'b0;
  logic [31:0]          ans_header = '0;
  logic [BW-1:0]        ans_payload = '0;
  logic [15:0]          ans_len = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [31:0]          rsp_header;
  logic [BW-1:0]        rsp_payload;
  logic [7:0]           bmRequestType;
  logic [7:0]           bRequest;
  logic [15:0]          wLength;
  logic                 timeout_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]   hdr;
    logic [BW-1:0] pay;
    logic [15:0]   wl;
    logic [7:0]    bm;
    logic [7:0]    br;
  } exp_t;
  exp_t sb[$];

  auth_responder_mc #(
    .MSG_LEN(MSG_LEN), .NUM_SLOTS(NUM_SLOTS), .QUEUE_DEPTH(QUEUE_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC), .PROTO_VER(8'h01)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_msg(req_msg),
    .slot_valid_mask(slot_valid_mask), .busy_in(busy_in),
    .ans_start(ans_start), .ans_type(ans_type), .ans_slot(ans_slot),
    .ans_req_body(ans_req_body), .ans_done(ans_done), .ans_error(ans_error),
    .ans_header(ans_header), .ans_payload(ans_payload), .ans_len(ans_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_header(rsp_header),
    .rsp_payload(rsp_payload), .bmRequestType(bmRequestType), .bRequest(bRequest),
    .wLength(wLength), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t err_exp(input logic [7:0] code);
    exp_t e;
    e.hdr = {8'h01, 8'h7F, code, 8'h00};
    e.pay = '0;
    e.wl  = 16'd4;
    e.bm  = 8'h00;
    e.br  = 8'h19;
    return e;
  endfunction

  function automatic exp_t ans_exp(input logic [31:0] h, input logic [BW-1:0] p,
                                   input logic [15:0] wl, input logic dig);
    exp_t e;
    e.hdr = h;
    e.pay = p;
    e.wl  = wl;
    e.bm  = dig ? 8'h80 : 8'h00;
    e.br  = dig ? 8'h18 : 8'h19;
    return e;
  endfunction

  // Offers one request and returns in the cycle after it was accepted.
  task automatic push_req(input logic [MSG_LEN-1:0] msg);
    int n;
    n = 0;
    req_msg   = msg;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 64) begin tick(); n++; end
    if (req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL push_ready: got req_ready=%b want 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  // Waits for a response, compares it with the scoreboard head while rsp_ready
  // is held low for 'hold' cycles, then completes the handshake.
  task automatic expect_rsp(input string name, input int hold);
    exp_t e;
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 64) begin tick(); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s.wait: got rsp_valid=%b want 1", name, rsp_valid);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s.sb: got response %h with no expectation queued", name, rsp_header);
    end else begin
      e = sb.pop_front();
      for (int c = 0; c <= hold; c++) begin
        if (c > 0) tick();
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL %s.valid[%0d]: got %b want 1", name, c, rsp_valid); end
        checks++; if (rsp_header !== e.hdr) begin failures++; $display("FAIL %s.hdr[%0d]: got %h want %h", name, c, rsp_header, e.hdr); end
        checks++; if (rsp_payload !== e.pay) begin failures++; $display("FAIL %s.pay[%0d]: got %h want %h", name, c, rsp_payload, e.pay); end
        checks++; if (wLength !== e.wl) begin failures++; $display("FAIL %s.wLength[%0d]: got %0d want %0d", name, c, wLength, e.wl); end
        checks++; if (bmRequestType !== e.bm) begin failures++; $display("FAIL %s.bm[%0d]: got %h want %h", name, c, bmRequestType, e.bm); end
        checks++; if (bRequest !== e.br) begin failures++; $display("FAIL %s.bReq[%0d]: got %h want %h", name, c, bRequest, e.br); end
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL %s.release: got rsp_valid=%b want 0", name, rsp_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (ans_start !== 1'b0) begin failures++; $display("FAIL rst_ans_start: got %b want 0", ans_start); end
    checks++; if (wLength !== 16'd0) begin failures++; $display("FAIL rst_wLength: got %0d want 0", wLength); end
    reset = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_digest();
    slot_valid_mask = 4'b0011;
    sb.push_back(ans_exp(32'h1234_5678, 32'hCAFE_F00D, 16'd68, 1'b1));
    push_req({8'h01, 8'h81, 8'h00, 8'h00, 32'hDEAD_BEEF});
    tick();
    checks++; if (ans_start !== 1'b0) begin failures++; $display("FAIL dig_early_start: got %b want 0", ans_start); end
    tick();
    checks++; if (ans_start !== 1'b1) begin failures++; $display("FAIL dig_start: got %b want 1", ans_start); end
    checks++; if (ans_type !== 2'd0) begin failures++; $display("FAIL dig_type: got %0d want 0", ans_type); end
    checks++; if (ans_slot !== 2'd0) begin failures++; $display("FAIL dig_slot: got %0d want 0", ans_slot); end
    checks++; if (ans_req_body !== 32'hDEAD_BEEF) begin failures++; $display("FAIL dig_body: got %h want deadbeef", ans_req_body); end
    tick();
    checks++; if (ans_start !== 1'b0) begin failures++; $display("FAIL dig_start_pulse: got %b want 0", ans_start); end
    repeat (4) tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL dig_early_rsp: got %b want 0", rsp_valid); end
    ans_done = 1'b1; ans_header = 32'h1234_5678; ans_payload = 32'hCAFE_F00D; ans_len = 16'd99;
    tick();
    ans_done = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL dig_rsp_latency: got %b want 1", rsp_valid); end
    expect_rsp("digest", 0);
  endtask

  task automatic test_challenge();
    slot_valid_mask = 4'b0100;
    sb.push_back(ans_exp(32'hA5A5_0183, 32'h1122_3344, 16'd48, 1'b0));
    push_req({8'h01, 8'h83, 8'h02, 8'h00, 32'h0BAD_CAFE});
    tick(); tick();
    checks++; if (ans_start !== 1'b1) begin failures++; $display("FAIL chal_start: got %b want 1", ans_start); end
    checks++; if (ans_type !== 2'd2) begin failures++; $display("FAIL chal_type: got %0d want 2", ans_type); end
    checks++; if (ans_slot !== 2'd2) begin failures++; $display("FAIL chal_slot: got %0d want 2", ans_slot); end
    checks++; if (ans_req_body !== 32'h0BAD_CAFE) begin failures++; $display("FAIL chal_body: got %h want 0badcafe", ans_req_body); end
    tick(); tick();
    ans_done = 1'b1; ans_header = 32'hA5A5_0183; ans_payload = 32'h1122_3344; ans_len = 16'd48;
    tick();
    ans_done = 1'b0;
    expect_rsp("challenge", 3);
  endtask

  task automatic test_engine_error();
    slot_valid_mask = 4'b0001;
    sb.push_back(err_exp(8'h04));
    push_req({8'h01, 8'h82, 8'h00, 8'h00, 32'h0000_0040});
    tick(); tick(); tick();
    ans_done = 1'b1; ans_error = 1'b1; ans_header = 32'hFFFF_FFFF;
    tick();
    ans_done = 1'b0; ans_error = 1'b0;
    expect_rsp("engine_error", 0);
  endtask

  task automatic test_error_matrix();
    logic [31:0] hdr_t  [7];
    logic        busy_t [7];
    logic [3:0]  mask_t [7];
    logic [7:0]  code_t [7];
    hdr_t  = '{32'h0281_0000, 32'h0185_0000, 32'h0181_0000, 32'h0182_0300,
               32'h0183_0400, 32'h0285_0000, 32'h0185_0700};
    busy_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    mask_t = '{4'b0011, 4'b0011, 4'b0011, 4'b0111, 4'b1111, 4'b0011, 4'b0011};
    code_t = '{8'h02, 8'h01, 8'h03, 8'h01, 8'h01, 8'h02, 8'h01};
    for (int i = 0; i < 7; i++) begin
      busy_in = busy_t[i];
      slot_valid_mask = mask_t[i];
      sb.push_back(err_exp(code_t[i]));
      push_req({hdr_t[i], 32'h5555_0000 + 32'(i)});
      tick(); tick();
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL err%0d_latency: got %b want 1", i, rsp_valid); end
      checks++; if (ans_start !== 1'b0) begin failures++; $display("FAIL err%0d_no_dispatch: got %b want 0", i, ans_start); end
      expect_rsp($sformatf("err%0d", i), 0);
      busy_in = 1'b0;
    end
  endtask

  task automatic test_timeout();
    slot_valid_mask = 4'b0011;
    sb.push_back(err_exp(8'h04));
    push_req({8'h01, 8'h81, 8'h00, 8'h00, 32'h0});
    tick(); tick(); tick();
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_early[%0d]: got %b want 0", i, timeout_err); end
      tick();
    end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_pulse: got %b want 1", timeout_err); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL to_rsp_early: got %b want 0", rsp_valid); end
    tick();
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_pulse_end: got %b want 0", timeout_err); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL to_rsp: got %b want 1", rsp_valid); end
    expect_rsp("timeout", 0);
  endtask

  task automatic test_timeout_race();
    slot_valid_mask = 4'b0011;
    sb.push_back(ans_exp(32'h0BEE_0081, 32'h7777_8888, 16'd68, 1'b1));
    push_req({8'h01, 8'h81, 8'h00, 8'h00, 32'h0000_0001});
    tick(); tick(); tick();
    repeat (TIMEOUT_CYC) tick();
    ans_done = 1'b1; ans_header = 32'h0BEE_0081; ans_payload = 32'h7777_8888; ans_len = 16'd99;
    #1;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL race_no_pulse: got %b want 0", timeout_err); end
    tick();
    ans_done = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL race_rsp: got %b want 1", rsp_valid); end
    expect_rsp("race", 0);
  endtask

  task automatic test_back_to_back();
    slot_valid_mask = 4'b0011;
    sb.push_back(ans_exp(32'hAAAA_0001, 32'h0000_00AA, 16'd68, 1'b1));
    sb.push_back(err_exp(8'h01));
    sb.push_back(err_exp(8'h02));
    push_req({8'h01, 8'h81, 8'h00, 8'h00, 32'h0000_000A});
    tick(); tick(); tick();
    req_valid = 1'b1; req_msg = {8'h01, 8'h85, 8'h00, 8'h00, 32'h0000_000B};
    tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL q_one_entry_ready: got %b want 1", req_ready); end
    req_msg = {8'h03, 8'h81, 8'h00, 8'h00, 32'h0000_000C};
    tick();
    req_msg = {8'h01, 8'h81, 8'h00, 8'h00, 32'h0000_000D};
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL q_full: got %b want 0", req_ready); end
    tick();
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL q_full_hold: got %b want 0", req_ready); end
    req_valid = 1'b0;
    ans_done = 1'b1; ans_header = 32'hAAAA_0001; ans_payload = 32'h0000_00AA; ans_len = 16'd7;
    tick();
    ans_done = 1'b0;
    expect_rsp("q_a", 0);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL q_idle_full: got %b want 0", req_ready); end
    tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL q_pop_frees: got %b want 1", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL q_b_latency: got %b want 1", rsp_valid); end
    expect_rsp("q_b", 0);
    expect_rsp("q_c", 0);
  endtask

  task automatic test_reset_midflight();
    logic seen;
    slot_valid_mask = 4'b0010;
    push_req({8'h01, 8'h83, 8'h01, 8'h00, 32'h1357_2468});
    tick(); tick(); tick();
    req_valid = 1'b1; req_msg = {8'h01, 8'h85, 8'h00, 8'h00, 32'h0000_00EE};
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL mrst_req_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mrst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (ans_start !== 1'b0) begin failures++; $display("FAIL mrst_ans_start: got %b want 0", ans_start); end
    checks++; if (ans_type !== 2'd0) begin failures++; $display("FAIL mrst_ans_type: got %0d want 0", ans_type); end
    checks++; if (ans_slot !== 2'd0) begin failures++; $display("FAIL mrst_ans_slot: got %0d want 0", ans_slot); end
    checks++; if (ans_req_body !== '0) begin failures++; $display("FAIL mrst_ans_body: got %h want 0", ans_req_body); end
    checks++; if (rsp_header !== 32'h0) begin failures++; $display("FAIL mrst_rsp_header: got %h want 0", rsp_header); end
    checks++; if (rsp_payload !== '0) begin failures++; $display("FAIL mrst_rsp_payload: got %h want 0", rsp_payload); end
    checks++; if (bmRequestType !== 8'h0 || bRequest !== 8'h0) begin failures++; $display("FAIL mrst_usb: got %h/%h want 00/00", bmRequestType, bRequest); end
    checks++; if (wLength !== 16'd0) begin failures++; $display("FAIL mrst_wLength: got %0d want 0", wLength); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL mrst_timeout_err: got %b want 0", timeout_err); end
    reset = 1'b0;
    tick();
    ans_done = 1'b1; ans_header = 32'hBAD0_BAD0; ans_payload = 32'hBAD1_BAD1;
    tick();
    ans_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid !== 1'b0 || ans_start !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mrst_flushed: got activity=%b want 0", seen); end

    sb.push_back(ans_exp(32'hC0DE_0182, 32'h0F0F_0F0F, 16'd40, 1'b0));
    push_req({8'h01, 8'h82, 8'h01, 8'h00, 32'h0000_0100});
    tick();
    tick();
    checks++; if (ans_start !== 1'b1 || ans_type !== 2'd1 || ans_slot !== 2'd1) begin
      failures++;
      $display("FAIL mrst_after_dispatch: got start=%b type=%0d slot=%0d want 1/1/1", ans_start, ans_type, ans_slot);
    end
    tick();
    ans_done = 1'b1; ans_header = 32'hC0DE_0182; ans_payload = 32'h0F0F_0F0F; ans_len = 16'd40;
    tick();
    ans_done = 1'b0;
    expect_rsp("after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_digest();
    test_challenge();
    test_engine_error();
    test_error_matrix();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_reset_midflight();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drained: got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
